mat_row_loader: RTL and testbench
=================================

MAT_ROW_LOADER -- requirements
Module: mat_row_loader

Interface
REQ-001 Parameter WIDTH, default 4, matrix dimension and elements per row.
REQ-002 Parameter CACHE_SIZE, default 4, number of matrix slots in the downstream MatCache.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin loading one WIDTH x WIDTH matrix.
REQ-007 dest_addr  input  $clog2(CACHE_SIZE)  destination cache slot, sampled on accepted start.
REQ-008 busy  output  1  high from the cycle after accepted start until done is asserted.
REQ-009 done  output  1  one-cycle pulse when the last row has been written.
REQ-010 in_valid  input  1  source presents a scalar element.
REQ-011 in_ready  output  1  loader accepts the element this cycle.
REQ-012 in_data  input  shortreal  scalar element, row-major order.
REQ-013 write_op  output  MatDataWriteOp_t  write command to MatCache.
REQ-014 write_addr1  output  $clog2(CACHE_SIZE)  cache slot for the write.
REQ-015 write_param  output  $clog2(WIDTH)  row index for the write.
REQ-016 data_in  output  shortreal [WIDTH-1:0]  assembled row to MatCache.

Function
REQ-017 The FSM SHALL have states IDLE, FILL, WRITE and DONE.
REQ-018 In IDLE, start=1 SHALL latch dest_addr, clear row and col counters, and move to FILL.
REQ-019 In FILL, in_ready SHALL be 1; each cycle with in_valid&&in_ready SHALL store in_data into buffer[col] and increment col.
REQ-020 Acceptance of element col=WIDTH-1 SHALL move the FSM to WRITE on the next edge.
REQ-021 In WRITE (exactly one cycle), in_ready SHALL be 0 and the outputs SHALL be write_op=MAT_DATA_WRITE_ROW, write_addr1=latched slot, write_param=row, data_in=buffer.
REQ-022 From WRITE, row=WIDTH-1 SHALL go to DONE; otherwise the FSM SHALL increment row, clear col and return to FILL.
REQ-023 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-024 Outside WRITE, write_op SHALL be MAT_DATA_WRITE_NONE and no cache write is implied.
REQ-025 in_ready SHALL be 0 in IDLE, WRITE and DONE; in_valid in those states SHALL be ignored and no data SHALL be lost.
REQ-026 start SHALL be ignored while busy or in DONE.
REQ-027 Gaps in in_valid SHALL stall FILL with col unchanged.
REQ-028 Minimum latency with continuous in_valid, for WIDTH=4: start at cycle 0, FILL begins at cycle 1, WRITE cycles 5/10/15/20, done at cycle 21.
REQ-029 Counters SHALL wrap-free: col counts 0..WIDTH-1 and row counts 0..WIDTH-1 only.
REQ-030 data_in SHALL hold the last buffer contents outside WRITE; the downstream cache SHALL act only on write_op.

Reset
REQ-031 Reset SHALL force IDLE, busy=0, done=0, in_ready=0, write_op=MAT_DATA_WRITE_NONE, write_addr1=0, write_param=0, col=0, row=0.
REQ-032 Reset during FILL or WRITE SHALL abandon the matrix; no further write SHALL issue, and the partial buffer SHALL be discarded.
REQ-033 If reset and start are asserted together, reset SHALL win.

Structure
REQ-034 MatDataWriteOp_t, including MAT_DATA_WRITE_NONE and MAT_DATA_WRITE_ROW, SHALL live in the shared mat package with MatDataReadOp_t.
REQ-035 Loader state typedef SHALL live in the shared mat package.
REQ-036 A single sub-module, mat_row_buffer (WIDTH-entry shortreal register with indexed write), is natural; everything else stays flat.

Verification
REQ-037 Continuous stream: start, dest_addr=2, elements 1.0..16.0 -> four ROW writes to slot 2, params 0..3, row0=(1,2,3,4), row3=(13,14,15,16); done at cycle 21.
REQ-038 Bubbles: in_valid low every other cycle -> identical writes and values to REQ-037, with done delayed by the number of bubble cycles.
REQ-039 Backpressure: in_valid held high during WRITE -> in_ready=0 that cycle, and the held element is accepted as col 0 of the next row.
REQ-040 start pulsed mid-load with dest_addr=3 -> ignored; all writes keep write_addr1=2.
REQ-041 Reset asserted after row 1 is written -> no further writes, busy=0; a new start with dest_addr=0 loads cleanly from row 0.
REQ-042 End-to-end with MatCache: load (4,6,1,6),(1,2,3,4),(3,3,3,3),(9,7,5,3) -> READ_DIAG with param 0 returns (4,4,3,7).

Source files
------------

// File: rtl/mat_row_loader_pkg.sv
// mat_row_loader_pkg: shared MatCache op types, loader states and the scalar element type.
package mat_row_loader_pkg;
  // Elements travel as IEEE-754 single-precision (shortreal) bit patterns.
  typedef logic [31:0] fp32_t;
  typedef enum logic [1:0] {
    MAT_DATA_WRITE_NONE = 2'd0,
    MAT_DATA_WRITE_ROW  = 2'd1,
    MAT_DATA_WRITE_DIAG = 2'd2
  } MatDataWriteOp_t;
  typedef enum logic [1:0] {
    MAT_DATA_READ_NONE = 2'd0,
    MAT_DATA_READ_ROW  = 2'd1,
    MAT_DATA_READ_DIAG = 2'd2
  } MatDataReadOp_t;
  typedef logic [1:0] loader_state_t;
  localparam loader_state_t ST_IDLE  = 2'd0;
  localparam loader_state_t ST_FILL  = 2'd1;
  localparam loader_state_t ST_WRITE = 2'd2;
  localparam loader_state_t ST_DONE  = 2'd3;
endpackage

// File: rtl/mat_row_loader_buffer.sv
// mat_row_buffer: WIDTH-entry element register with indexed write; reset discards partial rows.
module mat_row_buffer
  import mat_row_loader_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(WIDTH)-1:0] idx,
  input  fp32_t                    wdata,
  output fp32_t [WIDTH-1:0]        rows
);
  always_ff @(posedge clock)
    if (reset) rows <= '0;
    else if (we) rows[idx] <= wdata;
endmodule

// File: rtl/mat_row_loader.sv
// mat_row_loader: gathers a row-major scalar stream into rows and issues one MatCache row write per row.
module mat_row_loader
  import mat_row_loader_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int CACHE_SIZE = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(CACHE_SIZE)-1:0] dest_addr,
  output logic                          busy,
  output logic                          done,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  fp32_t                         in_data,
  output MatDataWriteOp_t               write_op,
  output logic [$clog2(CACHE_SIZE)-1:0] write_addr1,
  output logic [$clog2(WIDTH)-1:0]      write_param,
  output fp32_t [WIDTH-1:0]             data_in
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(CACHE_SIZE);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  loader_state_t state;
  logic [CW-1:0] row, col;
  logic [AW-1:0] slot;
  logic accept;
  assign in_ready    = state == ST_FILL;
  assign accept      = in_ready && in_valid;
  assign busy        = in_ready || state == ST_WRITE;
  assign done        = state == ST_DONE;
  assign write_op    = state == ST_WRITE ? MAT_DATA_WRITE_ROW : MAT_DATA_WRITE_NONE;
  assign write_addr1 = slot;
  assign write_param = row;
  mat_row_buffer #(.WIDTH(WIDTH)) u_buf (
    .clock (clock),
    .reset (reset),
    .we    (accept),
    .idx   (col),
    .wdata (in_data),
    .rows  (data_in)
  );
  // col parks at LAST after the final element; WRITE clears it, so neither counter wraps.
  always_ff @(posedge clock)
    if (reset) begin
      state <= ST_IDLE;
      row   <= '0;
      col   <= '0;
      slot  <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (start) begin
            slot  <= dest_addr;
            row   <= '0;
            col   <= '0;
            state <= ST_FILL;
          end
        ST_FILL:
          if (in_valid) begin
            if (col == LAST) state <= ST_WRITE;
            else col <= col + 1'b1;
          end
        ST_WRITE:
          if (row == LAST) state <= ST_DONE;
          else begin
            row   <= row + 1'b1;
            col   <= '0;
            state <= ST_FILL;
          end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mat_row_loader.sv
// tb_mat_row_loader: directed loads with a MatCache model; checks timing, handshake, write ops and reset.
module tb_mat_row_loader;
  import mat_row_loader_pkg::*;
  logic clock = 0, reset = 1, start = 0, in_valid = 0;
  logic [1:0] dest_addr = 0;
  fp32_t in_data = 0;
  logic busy, done, in_ready;
  MatDataWriteOp_t write_op;
  logic [1:0] write_addr1, write_param;
  fp32_t [3:0] data_in;
  fp32_t [3:0] cache [0:3][0:3];
  fp32_t mat [0:15];
  logic [1:0] exp_slot = 0;
  int checks = 0, errors = 0, nwrites = 0, seq_err = 0, dcyc;

  mat_row_loader #(.WIDTH(4), .CACHE_SIZE(4)) dut (
    .clock(clock), .reset(reset), .start(start), .dest_addr(dest_addr),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .write_op(write_op), .write_addr1(write_addr1),
    .write_param(write_param), .data_in(data_in)
  );

  always #5 clock = ~clock;

  // MatCache model: store rows and flag writes to the wrong slot or out of row order.
  always @(posedge clock)
    if (write_op == MAT_DATA_WRITE_ROW) begin
      if (write_addr1 != exp_slot || int'(write_param) != nwrites % 4) seq_err++;
      cache[write_addr1][write_param] = data_in;
      nwrites++;
    end

  function automatic fp32_t fp(input int n);
    case (n)
      1: fp = 32'h3f800000;  2: fp = 32'h40000000;  3: fp = 32'h40400000;  4: fp = 32'h40800000;
      5: fp = 32'h40a00000;  6: fp = 32'h40c00000;  7: fp = 32'h40e00000;  8: fp = 32'h41000000;
      9: fp = 32'h41100000; 10: fp = 32'h41200000; 11: fp = 32'h41300000; 12: fp = 32'h41400000;
      13: fp = 32'h41500000; 14: fp = 32'h41600000; 15: fp = 32'h41700000; 16: fp = 32'h41800000;
      default: fp = 32'h0;
    endcase
  endfunction

  function automatic fp32_t [3:0] row4(input int a, b, c, d);
    row4 = {fp(d), fp(c), fp(b), fp(a)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One load; cycle 0 is the start cycle. Bubbles drop in_valid on even cycles.
  task automatic load(input logic [1:0] dest, input bit bub, input bit mid, output int dc);
    int k, cyc, period, edone;
    bit acc, wexp;
    period = bub ? 8 : 5;
    edone = bub ? 33 : 21;
    nwrites = 0; seq_err = 0; exp_slot = dest;
    start = 1; dest_addr = dest; in_valid = 0;
    tick();
    start = 0; k = 0; cyc = 1; dc = -1;
    while (cyc < 100 && dc < 0) begin
      wexp = cyc % period == 0;
      chk("write_op", 128'(write_op), wexp ? 128'(MAT_DATA_WRITE_ROW) : 128'(MAT_DATA_WRITE_NONE));
      chk("in_ready", 128'(in_ready), 128'(!wexp && cyc < edone));
      chk("busy", 128'(busy), 128'(cyc < edone));
      chk("done", 128'(done), 128'(cyc == edone));
      if (done) dc = cyc;
      in_valid = k < 16 && !(bub && cyc % 2 == 0);
      in_data = mat[k < 16 ? k : 15];
      start = mid && cyc == 7;
      dest_addr = (mid && cyc == 7) ? 2'd3 : dest;
      acc = in_valid && in_ready;
      @(posedge clock);
      if (acc) k++;
      #1;
      cyc++;
    end
    in_valid = 0; start = 0;
    chk("done_cycle", 128'(dc), 128'(edone));
    chk("write_count", 128'(nwrites), 128'd4);
    chk("write_seq", 128'(seq_err), 128'd0);
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 4; r++) cache[s][r] = '0;
    for (int i = 0; i < 16; i++) mat[i] = fp(i + 1);
    tick(); tick();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_ready", 128'(in_ready), 128'd0);
    chk("rst_op", 128'(write_op), 128'(MAT_DATA_WRITE_NONE));
    chk("rst_addr", 128'(write_addr1), 128'd0);
    chk("rst_param", 128'(write_param), 128'd0);
    reset = 0;
    tick();

    load(2'd2, 1'b0, 1'b0, dcyc);
    chk("cont_row0", cache[2][0], row4(1, 2, 3, 4));
    chk("cont_row1", cache[2][1], row4(5, 6, 7, 8));
    chk("cont_row3", cache[2][3], row4(13, 14, 15, 16));
    chk("hold_data", data_in, row4(13, 14, 15, 16));
    tick();

    for (int r = 0; r < 4; r++) cache[2][r] = '0;
    load(2'd2, 1'b1, 1'b0, dcyc);
    chk("bub_row0", cache[2][0], row4(1, 2, 3, 4));
    chk("bub_row2", cache[2][2], row4(9, 10, 11, 12));
    chk("bub_row3", cache[2][3], row4(13, 14, 15, 16));
    tick();

    for (int r = 0; r < 4; r++) cache[2][r] = '0;
    load(2'd2, 1'b0, 1'b1, dcyc);
    chk("mid_row1", cache[2][1], row4(5, 6, 7, 8));
    chk("mid_slot3", cache[3][0], 128'd0);
    tick();

    // Abandon a load after row 1 is written.
    nwrites = 0; seq_err = 0; exp_slot = 2'd2;
    start = 1; dest_addr = 2'd2;
    tick();
    start = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1; in_data = fp(k + 17);
      tick();
    end
    in_valid = 0;
    tick();
    chk("pre_rst_writes", 128'(nwrites), 128'd2);
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_ready", 128'(in_ready), 128'd0);
    chk("abort_param", 128'(write_param), 128'd0);
    chk("abort_addr", 128'(write_addr1), 128'd0);
    chk("abort_buf", data_in, 128'd0);
    in_valid = 1;
    for (int k = 0; k < 8; k++) tick();
    in_valid = 0;
    chk("abort_nowrite", 128'(nwrites), 128'd2);
    reset = 1; start = 1;
    tick();
    reset = 0; start = 0;
    tick();
    chk("rst_wins", 128'(busy), 128'd0);

    mat = '{fp(4), fp(6), fp(1), fp(6), fp(1), fp(2), fp(3), fp(4),
            fp(3), fp(3), fp(3), fp(3), fp(9), fp(7), fp(5), fp(3)};
    load(2'd0, 1'b0, 1'b0, dcyc);
    chk("e2e_row0", cache[0][0], row4(4, 6, 1, 6));
    chk("e2e_row3", cache[0][3], row4(9, 7, 5, 3));
    // READ_DIAG param p picks element (p - i) mod WIDTH from row i.
    chk("e2e_diag", {cache[0][3][1], cache[0][2][2], cache[0][1][3], cache[0][0][0]},
        row4(4, 4, 3, 7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
